// File: rtl/div_pkg.sv
// Widths and FSM state encoding shared by the 8/4 divider and its
// shift-add multiplier checker.
package div_pkg;

  localparam int QW = 8;
  localparam int BW = 4;
  localparam int PW = QW + BW;
  localparam int CW = $clog2(BW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/mul_8x4_seq_if.sv
// Operand and result valid/ready bus of the shift-add multiplier.
// The slave side is the multiplier; the master side feeds operands and consumes products.
interface mul_8x4_seq_if;
  import div_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] q;
  logic [BW-1:0] b;
  logic [QW-1:0] r;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;

  modport slave (
    input  in_valid, q, b, r, out_ready,
    output in_ready, out_valid, product
  );

  modport master (
    output in_valid, q, b, r, out_ready,
    input  in_ready, out_valid, product
  );

endinterface

// File: rtl/mul_sa_step.sv
// One combinational shift-add step: conditionally add the shifted multiplicand,
// then advance the multiplicand and multiplier by one bit.
module mul_sa_step
  import div_pkg::*;
(
  input  logic [PW-1:0] acc,
  input  logic [PW-1:0] q_sh,
  input  logic [BW-1:0] b_sh,
  output logic [PW-1:0] acc_next,
  output logic [PW-1:0] q_sh_next,
  output logic [BW-1:0] b_sh_next
);

  always_comb begin
    acc_next  = b_sh[0] ? (acc + q_sh) : acc;
    q_sh_next = q_sh << 1;
    b_sh_next = b_sh >> 1;
  end

endmodule

// File: rtl/mul_8x4_seq.sv
// Sequential multiplier-accumulator: product = q*b + r, one multiplier bit
// per clock, between a valid/ready operand stage and a valid/ready result stage.
module mul_8x4_seq
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mul_8x4_seq_if.slave  bus
);

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] acc;
  logic [PW-1:0] q_sh;
  logic [BW-1:0] b_sh;
  logic [CW-1:0] cnt;
  logic [PW-1:0] product_q;
  logic [PW-1:0] acc_next;
  logic [PW-1:0] q_sh_next;
  logic [BW-1:0] b_sh_next;
  logic          last_step;

  assign last_step = (cnt == CW'(BW - 1));

  mul_sa_step u_step (
    .acc       (acc),
    .q_sh      (q_sh),
    .b_sh      (b_sh),
    .acc_next  (acc_next),
    .q_sh_next (q_sh_next),
    .b_sh_next (b_sh_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake outputs decode straight from the state register, so nothing
  // on the input side can reach them combinationally.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Always BW iterations, even for b==0, so latency never depends on data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      q_sh      <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            q_sh <= {{BW{1'b0}}, bus.q};
            b_sh <= bus.b;
            acc  <= {{BW{1'b0}}, bus.r};
            cnt  <= '0;
          end
        end
        RUN: begin
          acc  <= acc_next;
          q_sh <= q_sh_next;
          b_sh <= b_sh_next;
          cnt  <= cnt + CW'(1);
          if (last_step) begin
            product_q <= acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.product = product_q;

endmodule

// File: tb/tb_mul_8x4_seq.sv
// Randomized and directed bench for mul_8x4_seq against an arithmetic model
// (q*b + r) and the divider round-trip identity A == (A/B)*B + A%B.
module tb_mul_8x4_seq;
  import div_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mul_8x4_seq_if bus ();

  mul_8x4_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
               tag, observed, observed, expected, expected);
    end
  endtask

  // Present operands and hold in_valid until the block takes them.
  task automatic applyStimulus(input int qv, input int bv, input int rv);
    int n;
    @(negedge clk);
    bus.q        = QW'(qv);
    bus.b        = BW'(bv);
    bus.r        = QW'(rv);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 20);
    if (!bus.out_valid) checkOutput("valid_timeout", 0, 1);
  endtask

  // Full transaction with out_ready held high: latency, result, and return to idle.
  task automatic runOp(input int qv, input int bv, input int rv, input int expected);
    int lat;
    bus.out_ready = 1'b1;
    applyStimulus(qv, bv, rv);
    waitValid(lat);
    checkOutput("latency", lat, BW);
    checkOutput("product", int'(bus.product), expected);
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", int'(bus.out_valid), 0);
    checkOutput("ready_after_done", int'(bus.in_ready), 1);
  endtask

  initial begin
    int lat;
    int qv, bv, rv;
    int held;
    int extra;

    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.q        = '0;
    bus.b        = '0;
    bus.r        = '0;
    bus.out_ready = 1'b1;

    // Reset with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'($urandom);
      bus.q         = QW'($urandom);
      bus.b         = BW'($urandom);
      bus.r         = QW'($urandom);
      bus.out_ready = 1'($urandom);
    end
    #1;
    checkOutput("rst_in_ready", int'(bus.in_ready), 1);
    checkOutput("rst_out_valid", int'(bus.out_valid), 0);
    checkOutput("rst_product", int'(bus.product), 0);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;

    $display("[TB] basic and extreme operands");
    runOp(8'h23, 4'h6, 8'h05, 12'h0D7);
    runOp(8'hFF, 4'hF, 8'hFF, 12'hFF0);
    runOp(8'h10, 4'h0, 8'h07, 12'h007);
    runOp(8'h00, 4'hF, 8'h00, 12'h000);

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(8'h9A, 4'hB, 8'h11);
    waitValid(lat);
    checkOutput("bp_latency", lat, BW);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", int'(bus.out_valid), 1);
      checkOutput("bp_product", int'(bus.product), 8'h9A * 4'hB + 8'h11);
      checkOutput("bp_in_ready", int'(bus.in_ready), 0);
      bus.in_valid = 1'(i);
      bus.q        = QW'($urandom);
      bus.b        = BW'($urandom);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", int'(bus.out_valid), 0);
    checkOutput("bp_release_ready", int'(bus.in_ready), 1);
    checkOutput("bp_product_hold", int'(bus.product), 8'h9A * 4'hB + 8'h11);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    checkOutput("bp_no_second_op", extra, 0);

    $display("[TB] reset during RUN");
    applyStimulus(8'h55, 4'hF, 8'h03);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", int'(bus.out_valid), 0);
    checkOutput("abort_in_ready", int'(bus.in_ready), 1);
    checkOutput("abort_product", int'(bus.product), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    held = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) held++;
    end
    checkOutput("abort_no_valid", held, 0);
    runOp(8'h02, 4'h3, 8'h01, 12'h007);

    $display("[TB] random operands");
    for (int i = 0; i < 40; i++) begin
      qv = int'($urandom_range(255, 0));
      bv = int'($urandom_range(15, 0));
      rv = int'($urandom_range(255, 0));
      runOp(qv, bv, rv, qv * bv + rv);
    end

    $display("[TB] divider round trip");
    for (int a = 0; a < 256; a++) begin
      for (int d = 1; d < 16; d++) begin
        runOp(a / d, d, a % d, a);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_8x4_seq.md
# mul_8x4_seq

Sequential shift-add multiplier-accumulator computing product = q·b + r for an 8-bit q, 4-bit b and 8-bit r, one multiplier bit per clock. It is the inverse path of the combinational 8-bit/4-bit divider: fed that divider's quotient, divisor and remainder, it reconstructs the original dividend. It sits behind a valid/ready input stage and drives a valid/ready result stage, so it can run as an in-line divider checker or a standalone small multiplier.

## Interface
- QW, 8, width of q and r
- BW, 4, width of b and number of iterations
- PW, QW+BW (12), width of product
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- q  input  QW  multiplicand (quotient), unsigned
- b  input  BW  multiplier (divisor), unsigned
- r  input  QW  addend (remainder), unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  PW  q·b + r, unsigned

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch q_sh={BW'b0,q}, b_sh=b, acc={BW'b0,r}, cnt=0; go to RUN.
- RUN:
  - Each cycle, if b_sh[0], acc += q_sh; then q_sh <<= 1, b_sh >>= 1, cnt++.
  - After the cycle with cnt==BW-1, go to DONE.
  - Fixed BW iterations: no early exit on b==0.
- DONE:
  - out_valid=1; product=acc.
  - On out_ready: go to IDLE.
- in_ready=0 in RUN and DONE. Operand changes and in_valid during RUN/DONE are ignored.
- Arithmetic: all unsigned, PW bits. The maximum is 255·15+255=4080, so there is no overflow and no carry-out port.
- product is a register. It updates only on entry to DONE and holds its value after the handshake until the next result.
- Reset values: in_ready=1, out_valid=0, product=0, state=IDLE, internal registers 0.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted and discarded. No out_valid is emitted for it.

## Timing
- Accept at edge k. RUN occupies edges k+1..k+4. out_valid rises after edge k+4, so latency is BW cycles from accept to valid.
- With out_ready held high: DONE lasts 1 cycle, then IDLE. Throughput is one operation per BW+2 cycles.
- While out_ready=0: out_valid and product stay stable, and in_ready stays 0.
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.

## Structure
- Shared package div_pkg holds:
  - width constants QW=8, BW=4, PW=12;
  - state enum {IDLE, RUN, DONE}.
- The divider block uses the same widths from div_pkg.
- Optional sub-module mul_sa_step: a combinational single shift-add step (acc, q_sh, b_sh in; updated values out). It is instantiated once and used iteratively.
- The FSM, counter and handshake stay in mul_8x4_seq.

## Test plan
- Reset: hold rst_n=0 with random inputs -> in_ready=1, out_valid=0, product=0x000.
- Basic: q=0x23, b=0x6, r=0x05, out_ready=1 -> out_valid exactly 4 cycles after accept, product=0x0D7 (215), then in_ready=1 within 1 cycle.
- Extremes:
  - q=0xFF, b=0xF, r=0xFF -> product=0xFF0.
  - q=0x10, b=0x0, r=0x07 -> product=0x007, still 4 cycles.
- Backpressure: out_ready=0 for 10 cycles after out_valid, with new in_valid and changed q pulsed meanwhile -> product and out_valid stable, in_ready=0, no second op started. Releasing out_ready completes exactly one transfer.
- Reset mid-operation: assert rst_n=0 two cycles into RUN -> no out_valid. The next op q=0x02, b=0x3, r=0x01 -> product=0x007.
- Round trip: for every A in 0..255 and B in 1..15, feed the divider's quotient and remainder as q and r with b=B -> product==A for all 3840 cases.
